// File: rtl/image_mem_responder_if.sv
// Handshake, data and preload signals between a memory initiator and the image memory responder.
interface image_mem_responder_if;
    logic       start_read;
    logic       start_write;
    logic [7:0] addr_r;
    logic [7:0] addr_w;
    logic [7:0] data_w;
    logic       load_en;
    logic [7:0] load_addr;
    logic [7:0] load_data;
    logic       busy;
    logic [7:0] data_r;
    logic       read_data_done;
    logic       write_done;
    logic       req_err;

    modport master (
        output start_read, start_write, addr_r, addr_w, data_w,
        output load_en, load_addr, load_data,
        input  busy, data_r, read_data_done, write_done, req_err
    );

    modport slave (
        input  start_read, start_write, addr_r, addr_w, data_w,
        input  load_en, load_addr, load_data,
        output busy, data_r, read_data_done, write_done, req_err
    );
endinterface

// File: rtl/image_mem_responder.sv
// Latency-modelled 8-bit image memory with read/write handshake, a one-entry pending
// write for simultaneous requests, a sticky request-error flag and a direct preload port.
module image_mem_responder #(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    image_mem_responder_if.slave  bus
);
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_WAIT = 3'd1;
    localparam logic [2:0] ST_RD_DONE = 3'd2;
    localparam logic [2:0] ST_WR_WAIT = 3'd3;
    localparam logic [2:0] ST_WR_DONE = 3'd4;

    localparam logic [3:0] WAIT_INIT = 4'(LATENCY - 1);

    logic [7:0] mem [0:DEPTH-1];
    logic [2:0] state;
    logic [3:0] wait_cnt;
    logic [7:0] rd_addr;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       pend_wr;
    logic [7:0] data_r_q;
    logic       req_err_q;
    logic       busy_int;
    logic       any_start;
    logic       wait_over;
    logic       rd_in_range;
    logic       wr_in_range;
    logic       load_in_range;

    // A pending write keeps busy asserted through RD_DONE so the gap is covered.
    assign busy_int = (state == ST_RD_WAIT) || (state == ST_WR_WAIT) ||
                      ((state == ST_RD_DONE) && pend_wr);
    assign any_start     = bus.start_read || bus.start_write;
    assign wait_over     = (wait_cnt == '0);
    assign rd_in_range   = (int'({24'd0, rd_addr}) < DEPTH);
    assign wr_in_range   = (int'({24'd0, wr_addr}) < DEPTH);
    assign load_in_range = (int'({24'd0, bus.load_addr}) < DEPTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            rd_addr   <= '0;
            wr_addr   <= '0;
            wr_data   <= '0;
            pend_wr   <= 1'b0;
            data_r_q  <= '0;
            req_err_q <= 1'b0;
        end else begin
            if (busy_int && any_start) begin
                req_err_q <= 1'b1;
            end
            case (state)
                ST_RD_WAIT, ST_WR_WAIT: begin
                    if (wait_over) begin
                        if (state == ST_RD_WAIT) begin
                            state    <= ST_RD_DONE;
                            data_r_q <= rd_in_range ? mem[rd_addr] : 8'h00;
                        end else begin
                            state <= ST_WR_DONE;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                default: begin
                    // pend_wr can only be set here in RD_DONE; the write launches without a new request.
                    if (pend_wr) begin
                        state    <= ST_WR_WAIT;
                        wait_cnt <= WAIT_INIT;
                        pend_wr  <= 1'b0;
                    end else if (any_start) begin
                        rd_addr  <= bus.addr_r;
                        wr_addr  <= bus.addr_w;
                        wr_data  <= bus.data_w;
                        wait_cnt <= WAIT_INIT;
                        pend_wr  <= bus.start_read && bus.start_write;
                        state    <= bus.start_read ? ST_RD_WAIT : ST_WR_WAIT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Memory contents survive reset; the rst gate keeps an aborted write from landing.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if ((state == ST_WR_WAIT) && wait_over) begin
                if (wr_in_range) begin
                    mem[wr_addr] <= wr_data;
                end
            end else if ((state == ST_IDLE) && bus.load_en && load_in_range) begin
                mem[bus.load_addr] <= bus.load_data;
            end
        end
    end

    assign bus.busy           = busy_int;
    assign bus.data_r         = data_r_q;
    assign bus.read_data_done = (state == ST_RD_DONE);
    assign bus.write_done     = (state == ST_WR_DONE);
    assign bus.req_err        = req_err_q;
endmodule

// File: tb/tb_image_mem_responder.sv
// Self-checking bench for image_mem_responder: directed scenarios plus randomized
// traffic checked against a transaction-level memory model.
module tb_image_mem_responder;
    localparam int LATENCY = 2;
    localparam int DEPTH   = 256;

    logic clk = 1'b0;
    logic rst;

    image_mem_responder_if bus ();

    image_mem_responder #(.LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] mem_m [256];
    logic [7:0] last_rd;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [7:0] ar,
                                 input logic [7:0] aw, input logic [7:0] dw);
        bus.start_read  = rd;
        bus.start_write = wr;
        bus.addr_r      = ar;
        bus.addr_w      = aw;
        bus.data_w      = dw;
        tick();
        bus.start_read  = 1'b0;
        bus.start_write = 1'b0;
    endtask

    task automatic waitPhase(input string tag);
        for (int i = 0; i < LATENCY; i++) begin
            checkOutput({tag, " busy"}, 32'(bus.busy), 32'd1);
            checkOutput({tag, " no_done"}, 32'({bus.read_data_done, bus.write_done}), 32'd0);
            tick();
        end
    endtask

    // Ends in the RD_DONE cycle so a following read can be issued back-to-back.
    task automatic doRead(input logic [7:0] a);
        applyStimulus(1'b1, 1'b0, a, 8'h00, 8'h00);
        waitPhase("rd");
        last_rd = mem_m[a];
        checkOutput("rd done", 32'(bus.read_data_done), 32'd1);
        checkOutput("rd busy_low", 32'(bus.busy), 32'd0);
        checkOutput("rd data", 32'(bus.data_r), 32'(last_rd));
    endtask

    task automatic doWrite(input logic [7:0] a, input logic [7:0] d);
        applyStimulus(1'b0, 1'b1, 8'h00, a, d);
        waitPhase("wr");
        mem_m[a] = d;
        checkOutput("wr done", 32'(bus.write_done), 32'd1);
        checkOutput("wr busy_low", 32'(bus.busy), 32'd0);
        checkOutput("wr data_r_held", 32'(bus.data_r), 32'(last_rd));
    endtask

    task automatic doBoth(input logic [7:0] ra, input logic [7:0] wa, input logic [7:0] wd);
        applyStimulus(1'b1, 1'b1, ra, wa, wd);
        waitPhase("both_rd");
        last_rd = mem_m[ra];
        checkOutput("both rd_done", 32'(bus.read_data_done), 32'd1);
        checkOutput("both busy_gap", 32'(bus.busy), 32'd1);
        checkOutput("both rd_data", 32'(bus.data_r), 32'(last_rd));
        tick();
        waitPhase("both_wr");
        mem_m[wa] = wd;
        checkOutput("both wr_done", 32'(bus.write_done), 32'd1);
        checkOutput("both wr_busy_low", 32'(bus.busy), 32'd0);
    endtask

    task automatic loadWord(input logic [7:0] a, input logic [7:0] d);
        bus.load_en   = 1'b1;
        bus.load_addr = a;
        bus.load_data = d;
        tick();
        bus.load_en   = 1'b0;
        mem_m[a]      = d;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " busy"}, 32'(bus.busy), 32'd0);
        checkOutput({tag, " rd_done"}, 32'(bus.read_data_done), 32'd0);
        checkOutput({tag, " wr_done"}, 32'(bus.write_done), 32'd0);
        checkOutput({tag, " data_r"}, 32'(bus.data_r), 32'd0);
        checkOutput({tag, " req_err"}, 32'(bus.req_err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] ra;
        logic [7:0] wa;
        logic [7:0] wd;
        int         op;

        rst             = 1'b1;
        bus.start_read  = 1'b0;
        bus.start_write = 1'b0;
        bus.addr_r      = 8'h00;
        bus.addr_w      = 8'h00;
        bus.data_w      = 8'h00;
        bus.load_en     = 1'b0;
        bus.load_addr   = 8'h00;
        bus.load_data   = 8'h00;
        last_rd         = 8'h00;
        tick();
        tick();
        checkResetOutputs("reset");
        rst = 1'b0;
        tick();

        for (int a = 0; a < 256; a++) begin
            wd = 8'($urandom_range(0, 255));
            if (a == 'h10) wd = 8'h5A;
            if (a == 'h40) wd = 8'h77;
            loadWord(8'(a), wd);
        end

        $display("[TB] preloaded read");
        doRead(8'h10);
        checkOutput("preload 0x10", 32'(bus.data_r), 32'h5A);
        tick();

        $display("[TB] write then read back");
        doWrite(8'h20, 8'hC3);
        tick();
        doRead(8'h20);
        checkOutput("readback 0x20", 32'(bus.data_r), 32'hC3);
        tick();

        $display("[TB] simultaneous read and write");
        doBoth(8'h10, 8'h30, 8'h11);
        tick();
        doRead(8'h30);
        checkOutput("readback 0x30", 32'(bus.data_r), 32'h11);

        $display("[TB] preload ignored outside IDLE");
        bus.load_en   = 1'b1;
        bus.load_addr = 8'h50;
        bus.load_data = ~mem_m[8'h50];
        tick();
        bus.load_en   = 1'b0;
        doRead(8'h50);
        tick();

        $display("[TB] randomized traffic");
        for (int n = 0; n < 40; n++) begin
            op = int'($urandom_range(0, 2));
            ra = 8'($urandom_range(0, 255));
            wa = 8'($urandom_range(0, 255));
            wd = 8'($urandom_range(0, 255));
            if (op == 0) doRead(ra);
            else if (op == 1) doWrite(wa, wd);
            else doBoth(ra, wa, wd);
            if ($urandom_range(0, 1) == 1) tick();
            tick();
            checkOutput("idle data_r_held", 32'(bus.data_r), 32'(last_rd));
        end

        $display("[TB] back-to-back read sweep");
        for (int a = 0; a < 256; a++) begin
            doRead(8'(a));
        end
        tick();
        checkOutput("sweep idle", 32'(bus.read_data_done), 32'd0);

        $display("[TB] request while busy");
        checkOutput("req_err clear", 32'(bus.req_err), 32'd0);
        applyStimulus(1'b1, 1'b0, 8'h10, 8'h00, 8'h00);
        bus.start_read = 1'b1;
        bus.addr_r     = 8'h20;
        tick();
        bus.start_read = 1'b0;
        checkOutput("req_err set", 32'(bus.req_err), 32'd1);
        for (int i = 1; i < LATENCY; i++) tick();
        last_rd = mem_m[8'h10];
        checkOutput("ignored rd_done", 32'(bus.read_data_done), 32'd1);
        checkOutput("ignored rd_data", 32'(bus.data_r), 32'(last_rd));
        tick();
        checkOutput("ignored no_launch", 32'({bus.busy, bus.read_data_done}), 32'd0);
        doWrite(8'h60, 8'hA5);
        tick();
        checkOutput("req_err sticky", 32'(bus.req_err), 32'd1);

        $display("[TB] reset during write");
        loadWord(8'h40, 8'h77);
        applyStimulus(1'b0, 1'b1, 8'h00, 8'h40, 8'h99);
        rst = 1'b1;
        #1;
        checkResetOutputs("mid_wr_reset");
        tick();
        rst     = 1'b0;
        last_rd = 8'h00;
        for (int i = 0; i < LATENCY + 2; i++) begin
            checkOutput("no wr_done after reset", 32'(bus.write_done), 32'd0);
            tick();
        end
        doRead(8'h40);
        checkOutput("aborted write 0x40", 32'(bus.data_r), 32'h77);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
